// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> ACCESS -> (WAIT) -> RESP, every output registered.
// Word width comes from `WORD_SIZE (defines.vh); define ARB_ROUND_ROBIN_EN for alternating tie grants.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module mem_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  p0_req,
  input  logic                  p1_req,
  input  logic                  p0_we,
  input  logic                  p1_we,
  input  logic [`WORD_SIZE-1:0] p0_addr,
  input  logic [`WORD_SIZE-1:0] p1_addr,
  input  logic [`WORD_SIZE-1:0] p0_wdata,
  input  logic [`WORD_SIZE-1:0] p1_wdata,
  output logic                  p0_ack,
  output logic                  p1_ack,
  output logic [`WORD_SIZE-1:0] p0_rdata,
  output logic [`WORD_SIZE-1:0] p1_rdata,
  output logic                  mem_load,
  output logic                  mem_store,
  output logic [`WORD_SIZE-1:0] mem_addr,
  output logic [`WORD_SIZE-1:0] mem_wdata,
  input  logic [`WORD_SIZE-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner,
  output logic [1:0]            dbg_state
);

  localparam int W = `WORD_SIZE;
  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Handshake: a requester raises req with we/addr/wdata and holds them until
  // its one-cycle ack; ports are sampled only in IDLE, so anything changed
  // after the grant is ignored, and a req still high after ack is a new request.

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_we;
  logic [2:0]     r_cnt;
  logic           r_owner;
  logic           r_p0_ack;
  logic           r_p1_ack;
  logic [W-1:0]   r_p0_rdata;
  logic [W-1:0]   r_p1_rdata;
  logic           r_mem_load;
  logic           r_mem_store;
  logic [W-1:0]   r_mem_addr;
  logic [W-1:0]   r_mem_wdata;
  logic           r_busy;

  logic           w_grant;
  logic           w_sel;
  logic           w_sel_we;
  logic [W-1:0]   w_sel_addr;
  logic [W-1:0]   w_sel_wdata;
  logic           w_done;
  logic [W-1:0]   w_rd_word;
  logic           w_we_d;
  logic [2:0]     w_cnt_d;
  logic           w_owner_d;
  logic           w_p0_ack_d;
  logic           w_p1_ack_d;
  logic [W-1:0]   w_p0_rdata_d;
  logic [W-1:0]   w_p1_rdata_d;
  logic           w_mem_load_d;
  logic           w_mem_store_d;
  logic [W-1:0]   w_mem_addr_d;
  logic [W-1:0]   w_mem_wdata_d;
  logic           w_busy_d;

  // Arbitration between the two ports for the IDLE-cycle grant.
  always_comb begin
    w_grant = (r_state == S_IDLE) && (p0_req || p1_req);
`ifdef ARB_ROUND_ROBIN_EN
    if (p0_req && p1_req) begin
      w_sel = ~r_owner;
    end else begin
      w_sel = ~p0_req;
    end
`else
    w_sel = ~p0_req;
`endif
    w_sel_we    = w_sel ? p1_we    : p0_we;
    w_sel_addr  = w_sel ? p1_addr  : p0_addr;
    w_sel_wdata = w_sel ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_cnt       <= 3'd0;
      r_owner     <= 1'b1;
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_mem_load  <= 1'b0;
      r_mem_store <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_we        <= w_we_d;
      r_cnt       <= w_cnt_d;
      r_owner     <= w_owner_d;
      r_p0_ack    <= w_p0_ack_d;
      r_p1_ack    <= w_p1_ack_d;
      r_p0_rdata  <= w_p0_rdata_d;
      r_p1_rdata  <= w_p1_rdata_d;
      r_mem_load  <= w_mem_load_d;
      r_mem_store <= w_mem_store_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_busy      <= w_busy_d;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (p0_req || p1_req) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = r_we ? S_RESP : S_WAIT;
      S_WAIT:   if (r_cnt == 3'd1) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle early so they land registered in the target state.
  always_comb begin
    w_we_d        = w_grant ? w_sel_we : r_we;
    w_owner_d     = w_grant ? w_sel : r_owner;
    w_cnt_d       = 3'd0;
    if (r_state == S_ACCESS && !r_we) begin
      w_cnt_d = LAT;
    end else if (r_state == S_WAIT && r_cnt != 3'd0) begin
      w_cnt_d = r_cnt - 3'd1;
    end
    w_mem_load_d  = w_grant && !w_sel_we;
    w_mem_store_d = w_grant && w_sel_we;
    w_mem_addr_d  = w_grant ? w_sel_addr  : '0;
    w_mem_wdata_d = w_grant ? w_sel_wdata : '0;
    w_done        = (w_state_nxt == S_RESP);
    w_rd_word     = (r_state == S_WAIT) ? mem_rdata : '0;
    w_p0_ack_d    = w_done && !r_owner;
    w_p1_ack_d    = w_done && r_owner;
    w_p0_rdata_d  = w_p0_ack_d ? w_rd_word : '0;
    w_p1_rdata_d  = w_p1_ack_d ? w_rd_word : '0;
    w_busy_d      = (w_state_nxt != S_IDLE);
  end

  assign p0_ack    = r_p0_ack;
  assign p1_ack    = r_p1_ack;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign mem_load  = r_mem_load;
  assign mem_store = r_mem_store;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign owner     = r_owner;
  assign dbg_state = r_state;

endmodule
